// File: rtl/btn_conditioner.sv
// Push-button front end: two-flop synchroniser, per-button stability debounce,
// registered press pulses and combinational chord/idle decodes.

module btn_channel #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic             db;
  logic [CNT_W-1:0] cnt;
  logic             qualify;

  assign qualify = (s2 != db) && (cnt == TERMINAL);
  assign level   = db;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Any agreement between s2 and db restarts the count, so short bounces never flip db.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db    <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      press <= qualify & s2;
      if (s2 == db) begin
        cnt <= '0;
      end else if (qualify) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic rst_n,
  input  logic up_raw,
  input  logic down_raw,
  input  logic left_raw,
  input  logic right_raw,
  input  logic mid_raw,
  output logic up_btn,
  output logic down_btn,
  output logic left_btn,
  output logic right_btn,
  output logic mid_btn,
  output logic up_press,
  output logic down_press,
  output logic left_press,
  output logic right_press,
  output logic mid_press,
  output logic chord,
  output logic idle
);

  logic [2:0] held_count;

  btn_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_up (
    .clk(clk), .rst_n(rst_n), .raw(up_raw), .level(up_btn), .press(up_press)
  );

  btn_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_down (
    .clk(clk), .rst_n(rst_n), .raw(down_raw), .level(down_btn), .press(down_press)
  );

  btn_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_left (
    .clk(clk), .rst_n(rst_n), .raw(left_raw), .level(left_btn), .press(left_press)
  );

  btn_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_right (
    .clk(clk), .rst_n(rst_n), .raw(right_raw), .level(right_btn), .press(right_press)
  );

  btn_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_mid (
    .clk(clk), .rst_n(rst_n), .raw(mid_raw), .level(mid_btn), .press(mid_press)
  );

  // Decodes come straight from the debounced flops, so they add no latency.
  assign held_count = {2'b00, up_btn} + {2'b00, down_btn} + {2'b00, left_btn}
                    + {2'b00, right_btn} + {2'b00, mid_btn};
  assign chord      = (held_count >= 3'd2);
  assign idle       = ~(up_btn | down_btn | left_btn | right_btn | mid_btn);

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner: directed scenarios plus randomized hold
// patterns, compared every cycle against a sliding-window behavioural model.

module tb_btn_conditioner;

  localparam int DC = 4;
  localparam int CW = 3;

  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, MID = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] raw;

  logic up_btn, down_btn, left_btn, right_btn, mid_btn;
  logic up_press, down_press, left_press, right_press, mid_press;
  logic chord, idle;

  logic [4:0] dut_btn;
  logic [4:0] dut_press;

  int vectors     = 0;
  int miscompares = 0;

  // Model: last two raw samples per button, and the s2 history since the last flip.
  bit samp [5][$];
  bit win  [5][$];
  bit m_db    [5];
  bit m_press [5];

  assign dut_btn   = {mid_btn, right_btn, left_btn, down_btn, up_btn};
  assign dut_press = {mid_press, right_press, left_press, down_press, up_press};

  btn_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_raw(raw[UP]), .down_raw(raw[DOWN]), .left_raw(raw[LEFT]),
    .right_raw(raw[RIGHT]), .mid_raw(raw[MID]),
    .up_btn(up_btn), .down_btn(down_btn), .left_btn(left_btn),
    .right_btn(right_btn), .mid_btn(mid_btn),
    .up_press(up_press), .down_press(down_press), .left_press(left_press),
    .right_press(right_press), .mid_press(mid_press),
    .chord(chord), .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int b = 0; b < 5; b++) begin
      samp[b].delete();
      win[b].delete();
      m_db[b]    = 1'b0;
      m_press[b] = 1'b0;
    end
  endtask

  // A level flips once the last DC synchronised samples since the previous flip all disagree with it.
  task automatic model_edge();
    bit s2;
    bit all_differ;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int b = 0; b < 5; b++) begin
      s2 = (samp[b].size() >= 2) ? samp[b][samp[b].size() - 2] : 1'b0;
      samp[b].push_back(raw[b]);
      if (samp[b].size() > 2) void'(samp[b].pop_front());
      m_press[b] = 1'b0;
      win[b].push_back(s2);
      if (win[b].size() > DC) void'(win[b].pop_front());
      all_differ = (win[b].size() == DC);
      foreach (win[b][i]) if (win[b][i] == m_db[b]) all_differ = 1'b0;
      if (all_differ) begin
        m_db[b] = ~m_db[b];
        m_press[b] = m_db[b];
        win[b].delete();
      end
    end
  endtask

  task automatic check_output(input string tag);
    logic [11:0] obs;
    logic [11:0] exp;
    int          held;
    logic [4:0]  eb;
    logic [4:0]  ep;
    held = 0;
    for (int b = 0; b < 5; b++) begin
      eb[b] = m_db[b];
      ep[b] = m_press[b];
      held += int'(m_db[b]);
    end
    exp = {(held == 0), (held >= 2), ep, eb};
    obs = {idle, chord, dut_press, dut_btn};
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h (idle,chord,press[4:0],btn[4:0])", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic [4:0] value);
    raw = value;
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_output(tag);
  endtask

  task automatic run(input int n, input string tag);
    repeat (n) step(tag);
  endtask

  initial begin
    int rise_at;
    int fall_at;
    int pulses;
    int toggles;
    logic prev;
    int hold_left [5];
    logic [4:0] rv;
    logic [7:0] bounce;

    rst_n = 1'b0;
    apply_stimulus(5'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_state");
    rst_n = 1'b1;
    run(3, "post_reset_idle");

    // Clean press of up: level after 6 edges, single pulse, chord stays low.
    apply_stimulus(5'b00001);
    rise_at = -1;
    pulses  = 0;
    for (int i = 1; i <= 20; i++) begin
      step("clean_press");
      if (up_btn && rise_at < 0) rise_at = i;
      if (up_press) pulses++;
    end
    check_count("clean_press_latency", rise_at, DC + 2);
    check_count("clean_press_pulses", pulses, 1);
    apply_stimulus(5'b0);
    run(10, "clean_release");

    // Bounce on left with 3-cycle highs is rejected.
    bounce = 8'b0111_0111;
    pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      apply_stimulus({2'b00, bounce[i], 2'b00});
      step("bounce");
      if (left_press || left_btn) pulses++;
    end
    apply_stimulus(5'b0);
    for (int i = 0; i < 10; i++) begin
      step("bounce_tail");
      if (left_press || left_btn) pulses++;
    end
    check_count("bounce_left_activity", pulses, 0);

    // Chord of down and right rising together, then right drops.
    apply_stimulus(5'b01010);
    run(12, "chord_press");
    apply_stimulus(5'b00010);
    fall_at = -1;
    for (int i = 1; i <= 12; i++) begin
      step("chord_release");
      if (!chord && fall_at < 0) fall_at = i;
    end
    check_count("chord_fall_latency", fall_at, DC + 2);
    apply_stimulus(5'b0);
    run(10, "chord_all_release");

    // Mid held past qualification then dropped: no pulse on the fall.
    apply_stimulus(5'b10000);
    pulses = 0;
    for (int i = 0; i < DC + 2 + 10; i++) begin
      step("mid_hold");
      if (mid_press) pulses++;
    end
    apply_stimulus(5'b0);
    fall_at = -1;
    for (int i = 1; i <= 12; i++) begin
      step("mid_release");
      if (mid_press) pulses++;
      if (!mid_btn && fall_at < 0) fall_at = i;
    end
    check_count("mid_fall_latency", fall_at, DC + 2);
    check_count("mid_pulses", pulses, 1);

    // Reset asserted mid-count while up stays held; full re-qualification afterwards.
    apply_stimulus(5'b00001);
    run(3, "reset_midcount_pre");
    rst_n = 1'b0;
    model_reset();
    #1;
    check_output("reset_async");
    run(2, "reset_held");
    rst_n = 1'b1;
    rise_at = -1;
    pulses  = 0;
    for (int i = 1; i <= 12; i++) begin
      step("reset_requalify");
      if (up_btn && rise_at < 0) rise_at = i;
      if (up_press) pulses++;
    end
    check_count("reset_requalify_latency", rise_at, DC + 2);
    check_count("reset_requalify_pulses", pulses, 1);
    apply_stimulus(5'b0);
    run(10, "reset_release");

    // Long hold on right: one pulse, one level change, no wrap.
    apply_stimulus(5'b01000);
    pulses  = 0;
    toggles = 0;
    prev    = right_btn;
    for (int i = 0; i < 1000; i++) begin
      step("long_hold");
      if (right_press) pulses++;
      if (right_btn !== prev) toggles++;
      prev = right_btn;
    end
    check_count("long_hold_pulses", pulses, 1);
    check_count("long_hold_toggles", toggles, 1);
    apply_stimulus(5'b0);
    run(10, "long_release");

    // Random hold lengths per button, spanning both sides of the debounce threshold.
    for (int b = 0; b < 5; b++) hold_left[b] = 0;
    rv = 5'b0;
    for (int i = 0; i < 1500; i++) begin
      for (int b = 0; b < 5; b++) begin
        if (hold_left[b] == 0) begin
          rv[b]        = $urandom_range(0, 1) != 0;
          hold_left[b] = $urandom_range(1, 2 * DC + 4);
        end
        hold_left[b]--;
      end
      apply_stimulus(rv);
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
